// File: rtl/riscv_defines.sv
// Shared RV32 definitions used by the MDU: word width, MDU funct3 encodings and
// the sequencer state encoding.
package riscv_defines;

  localparam int WORD_WIDTH     = 32;
  localparam int ITER_CNT_WIDTH = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_datapath.sv
// Radix-2 iterative multiply/divide engine: one shared adder runs shift-add for
// multiply and restoring shift-subtract for divide on operand magnitudes.
module mdu_iter_datapath #(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic                  iterate_i,
  input  logic [2:0]            op_i,
  input  logic [WORD_WIDTH-1:0] operand_a_i,
  input  logic [WORD_WIDTH-1:0] operand_b_i,
  output logic [WORD_WIDTH-1:0] result_o
);
  import riscv_defines::*;

  localparam int W = WORD_WIDTH;

  logic [2:0]     op_reg;
  logic           neg_reg;
  logic [W-1:0]   mag_reg;
  logic [2*W-1:0] acc_reg;

  logic           a_signed, b_signed, sign_a, sign_b, neg_in;
  logic [W-1:0]   mag_a, mag_b;
  logic           is_div;
  logic [W:0]     rem_shift, add_a, add_b;
  logic [W+1:0]   sum;
  logic           ge;
  logic [2*W-1:0] acc_iter;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   div_word, div_fix;

  // Operand conditioning at accept: magnitudes plus the final result sign
  always_comb begin
    a_signed = op_i[2] ? ~op_i[0] : (op_i != OP_MULHU);
    b_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
    sign_a   = a_signed & operand_a_i[W-1];
    sign_b   = b_signed & operand_b_i[W-1];
    mag_a    = sign_a ? -operand_a_i : operand_a_i;
    mag_b    = sign_b ? -operand_b_i : operand_b_i;
    if (op_i[2] && op_i[1]) neg_in = sign_a;
    else                    neg_in = sign_a ^ sign_b;
  end

  // Shared adder: multiply adds the multiplicand, divide adds ~divisor + 1
  always_comb begin
    is_div    = op_reg[2];
    rem_shift = acc_reg[2*W-1:W-1];
    add_a     = is_div ? rem_shift : {1'b0, acc_reg[2*W-1:W]};
    if (is_div)          add_b = ~{1'b0, mag_reg};
    else if (acc_reg[0]) add_b = {1'b0, mag_reg};
    else                 add_b = '0;
    sum = {1'b0, add_a} + {1'b0, add_b} + {{(W+1){1'b0}}, is_div};
    ge  = sum[W+1];
    if (is_div)
      acc_iter = {(ge ? sum[W-1:0] : rem_shift[W-1:0]), acc_reg[W-2:0], ge};
    else
      acc_iter = {sum[W:0], acc_reg[W-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_reg  <= '0;
      neg_reg <= 1'b0;
      mag_reg <= '0;
      acc_reg <= '0;
    end else if (clear_i) begin
      op_reg  <= '0;
      neg_reg <= 1'b0;
      mag_reg <= '0;
      acc_reg <= '0;
    end else if (load_i) begin
      op_reg  <= op_i;
      neg_reg <= neg_in;
      mag_reg <= op_i[2] ? mag_b : mag_a;
      acc_reg <= op_i[2] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
    end else if (iterate_i) begin
      acc_reg <= acc_iter;
    end
  end

  // Sign fixup: full-width negate for products, per-word negate for quotient/remainder
  always_comb begin
    prod_fix = neg_reg ? -acc_reg : acc_reg;
    div_word = op_reg[1] ? acc_reg[2*W-1:W] : acc_reg[W-1:0];
    div_fix  = neg_reg ? -div_word : div_word;
    if (op_reg[2])             result_o = div_fix;
    else if (op_reg == OP_MUL) result_o = prod_fix[W-1:0];
    else                       result_o = prod_fix[2*W-1:W];
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, fast-path detection,
// pipeline stall, completion strobe and flush handling around the iterative engine.
module mdu_sequencer #(
  parameter int WORD_WIDTH     = riscv_defines::WORD_WIDTH,
  parameter int ITER_CNT_WIDTH = riscv_defines::ITER_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [WORD_WIDTH-1:0] operand_a_i,
  input  logic [WORD_WIDTH-1:0] operand_b_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [WORD_WIDTH-1:0] result_o,
  output logic                  valid_o,
  output logic                  busy_o
);
  import riscv_defines::*;

  localparam logic [ITER_CNT_WIDTH-1:0] LAST_ITER = ITER_CNT_WIDTH'(WORD_WIDTH - 1);
  localparam logic [WORD_WIDTH-1:0]     MIN_INT   = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  mdu_state_e                state_reg, state_next;
  logic [ITER_CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                      fast_reg;
  logic [WORD_WIDTH-1:0]     fast_result_reg;

  logic                  accept, iterate;
  logic                  b_zero, overflow, fast_in;
  logic [WORD_WIDTH-1:0] fast_value, dp_result;

  // Divide fast paths: divide-by-zero and the signed MIN_INT / -1 overflow
  always_comb begin
    b_zero   = (operand_b_i == '0);
    overflow = ~op_i[0] && (operand_a_i == MIN_INT) && (operand_b_i == '1);
    fast_in  = op_i[2] && (b_zero || overflow);
    if (b_zero) fast_value = op_i[1] ? operand_a_i : '1;
    else        fast_value = op_i[1] ? '0 : MIN_INT;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    stall_o    = 1'b0;
    valid_o    = 1'b0;
    iterate    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept     = 1'b1;
          stall_o    = 1'b1;
          state_next = fast_in ? FINISH : CALC;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        iterate = 1'b1;
        if (cnt_reg == LAST_ITER) state_next = FINISH;
        else                      cnt_next   = cnt_reg + ITER_CNT_WIDTH'(1);
      end
      FINISH: begin
        valid_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      fast_reg        <= 1'b0;
      fast_result_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        fast_reg        <= fast_in;
        fast_result_reg <= fast_value;
      end else if (flush_i || state_reg == FINISH) begin
        fast_reg        <= 1'b0;
        fast_result_reg <= '0;
      end
    end
  end

  mdu_iter_datapath #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_datapath (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .clear_i    (flush_i),
    .iterate_i  (iterate),
    .op_i       (op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .result_o   (dp_result)
  );

  assign busy_o   = (state_reg != IDLE);
  assign result_o = valid_o ? (fast_reg ? fast_result_reg : dp_result) : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table through a result scoreboard,
// plus hand-written flush, async-reset and back-to-back sequences.
module tb_mdu_sequencer;
  import riscv_defines::*;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        stall_o, valid_o, busy_o;
  logic [31:0] result_o;

  int checks = 0;
  int passes = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  mdu_sequencer dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .op_i       (op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard: every completion strobe must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'b0, valid_o}, 32'd0);
      end else begin
        check("result", result_o, sb.pop_front());
        check("stall_at_valid", {31'b0, stall_o}, 32'd0);
      end
    end
  end

  // Drives one instruction (called just after a rising edge) and measures its latency
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int lat);
    int cycle = 0;
    int stalls = 0;
    start_i = 1'b1;
    op_i = op;
    operand_a_i = av;
    operand_b_i = bv;
    sb.push_back(exp);
    while (cycle < 100) begin
      @(negedge clk_i);
      if (valid_o) break;
      if (stall_o) stalls++;
      cycle++;
      @(posedge clk_i);
      #1;
      operand_a_i = $urandom;
      operand_b_i = $urandom;
    end
    check("latency", cycle, lat);
    check("stall_cycles", stalls, lat);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("valid_one_cycle", {31'b0, valid_o}, 32'd0);
    check("idle_after", {31'b0, busy_o}, 32'd0);
    $display("op=%0d a=%h b=%h exp=%h latency=%0d", op, av, bv, exp, cycle);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_cnt;
    int cyc;

    vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[2]  = '{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[3]  = '{OP_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{OP_REM,    32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[13] = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
    vecs[14] = '{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[15] = '{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[16] = '{OP_REMU,   32'd5,         32'd0,         32'd5,         1};
    vecs[17] = '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[18] = '{OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[19] = '{OP_DIV,    32'h8000_0000, 32'd3,         32'hD555_5556, 33};
    vecs[20] = '{OP_REM,    32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 33};
    vecs[21] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};

    rst_ni = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i = '0;
    operand_a_i = '0;
    operand_b_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk_i);
      #1;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Flush together with start in IDLE: nothing accepted
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i = OP_DIVU;
    operand_a_i = 32'd9;
    operand_b_i = 32'd3;
    @(negedge clk_i);
    check("flush_start_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_start_busy", {31'b0, busy_o}, 32'd0);
    $display("flush with start in IDLE: busy=%0b", busy_o);

    // Flush at CALC iteration 10, then a fresh DIVU 9 / 3
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i = OP_DIVU;
    operand_a_i = 32'd100;
    operand_b_i = 32'd7;
    repeat (11) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("pre_flush_busy", {31'b0, busy_o}, 32'd1);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check("post_flush_busy", {31'b0, busy_o}, 32'd0);
    check("post_flush_stall", {31'b0, stall_o}, 32'd0);
    $display("flush at iteration 10: busy=%0b stall=%0b", busy_o, stall_o);
    @(posedge clk_i);
    #1;
    issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Asynchronous reset between edges in the middle of CALC
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i = OP_MUL;
    operand_a_i = 32'd5;
    operand_b_i = 32'd6;
    repeat (6) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    start_i = 1'b0;
    #1;
    check("areset_stall", {31'b0, stall_o}, 32'd0);
    check("areset_busy", {31'b0, busy_o}, 32'd0);
    check("areset_valid", {31'b0, valid_o}, 32'd0);
    $display("async reset mid-CALC: stall=%0b busy=%0b valid=%0b", stall_o, busy_o, valid_o);
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    check("post_reset_busy", {31'b0, busy_o}, 32'd0);

    // Back-to-back MULs: second instruction held on start_i through FINISH
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i = OP_MUL;
    operand_a_i = 32'd3;
    operand_b_i = 32'd4;
    sb.push_back(32'd12);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk_i);
      if (valid_o) break;
      cyc++;
    end
    check("b2b_first_latency", cyc, 33);
    @(posedge clk_i);
    #1;
    operand_a_i = 32'hFFFF_FFFF;
    operand_b_i = 32'hFFFF_FFFF;
    sb.push_back(32'd1);
    @(negedge clk_i);
    check("b2b_accept_stall", {31'b0, stall_o}, 32'd1);
    idle_cnt = busy_o ? 0 : 1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk_i);
      #1;
      operand_a_i = $urandom;
      operand_b_i = $urandom;
      @(negedge clk_i);
      cyc++;
      if (valid_o) break;
      if (!busy_o) idle_cnt++;
    end
    check("b2b_idle_cycles", idle_cnt, 1);
    check("b2b_second_latency", cyc, 33);
    $display("back-to-back MUL: idle cycles=%0d second latency=%0d", idle_cnt, cyc);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
